// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, select codes and helpers for the digit scan path
// Contents:
//   state_t     scan FSM state (IDLE / BLANK / DRIVE)
//   SEL_D0..D3  4:1 nibble mux select codes, Gray ordered (00/01/11/10)
//   idx_to_sel  maps a digit index 0..3 to its mux select code
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BLANK = 2'b01,
        ST_DRIVE = 2'b10
    } state_t;

    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b11;
    localparam logic [1:0] SEL_D3 = 2'b10;

    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        logic [1:0] s;
        case (idx)
            2'd0:    s = SEL_D0;
            2'd1:    s = SEL_D1;
            2'd2:    s = SEL_D2;
            default: s = SEL_D3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/digit_pick.sv
// rtl/digit_pick.sv - rotate-priority search for the next enabled digit
// Ports:
//   cur_idx   in  2  digit currently shown; search starts at cur_idx+1
//   mask      in  4  per-digit enable mask
//   next_idx  out 2  first set bit at cur_idx+1, +2, +3, +0 (mod 4)
//   wrapped   out 1  next_idx <= cur_idx, i.e. the scan went round
//   none      out 1  mask is empty; next_idx is then meaningless
module digit_pick (
    input  logic [1:0] cur_idx,
    input  logic [3:0] mask,
    output logic [1:0] next_idx,
    output logic       wrapped,
    output logic       none
);

    logic [1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        next_idx = cur_idx;
        cand     = cur_idx;
        for (int k = 4; k >= 1; k--) begin
            cand = cur_idx + 2'(k);
            if (mask[cand]) begin
                next_idx = cand;
            end
        end
    end

    assign none    = (mask == 4'b0000);
    assign wrapped = (next_idx <= cur_idx);

endmodule

// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - seven-segment digit multiplexer with inter-digit blanking
// Ports:
//   clk          in  1  system clock, rising edge
//   rst_n        in  1  synchronous active-low reset
//   en           in  1  scan enable; 0 darkens the display on the next clock
//   digit_en     in  4  per-digit enable mask, sampled at IDLE exit and DRIVE end
//   sel          out 2  nibble mux select (Gray: 00,01,11,10 for digits 0..3)
//   an_n         out 4  active-low anodes, bit i = digit i
//   frame_start  out 1  one-cycle pulse when a scan frame begins
import display_pkg::*;

module digit_scan_ctrl #(
    parameter int DRIVE_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit_en,
    output logic [1:0] sel,
    output logic [3:0] an_n,
    output logic       frame_start
);

    localparam int MAX_CYCLES = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    state_t        state;
    logic [1:0]    cur_idx;
    logic [CW-1:0] cnt;

    logic [1:0]    pick_cur;
    logic [1:0]    next_idx;
    logic          wrapped;
    logic          none;

    // From IDLE, searching after index 3 yields the lowest enabled digit.
    assign pick_cur = (state == ST_IDLE) ? 2'd3 : cur_idx;

    digit_pick u_pick (
        .cur_idx  (pick_cur),
        .mask     (digit_en),
        .next_idx (next_idx),
        .wrapped  (wrapped),
        .none     (none)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cur_idx     <= 2'd0;
            cnt         <= '0;
            sel         <= SEL_D0;
            an_n        <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    an_n <= 4'hF;
                    cnt  <= '0;
                    if (en && !none) begin
                        state       <= ST_BLANK;
                        cur_idx     <= next_idx;
                        sel         <= idx_to_sel(next_idx);
                        frame_start <= 1'b1;
                    end
                end

                ST_BLANK: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        an_n  <= 4'hF;
                        cnt   <= '0;
                    end else if (cnt == BLANK_LAST) begin
                        state <= ST_DRIVE;
                        an_n  <= ~(4'b0001 << cur_idx);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_DRIVE: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        an_n  <= 4'hF;
                        cnt   <= '0;
                    end else if (cnt == DRIVE_LAST) begin
                        // Anodes go dark together with the sel update, so a
                        // new select is never presented to a lit digit.
                        an_n <= 4'hF;
                        cnt  <= '0;
                        if (none) begin
                            state <= ST_IDLE;
                        end else begin
                            state       <= ST_BLANK;
                            cur_idx     <= next_idx;
                            sel         <= idx_to_sel(next_idx);
                            frame_start <= wrapped;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    an_n  <= 4'hF;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
